// File: rtl/rvee_wb_stage.sv
// rvee_wb_stage: RVee pipeline writeback stage.
// Retires ALU results in one cycle. For loads it waits for the data-bus
// response or a timeout. It then extracts and extends the loaded value and
// drives a one-cycle register-file write strobe.
module rvee_wb_stage #(
  parameter int XLEN         = 32,
  parameter int N_REGS       = 32,
  parameter int LOAD_TIMEOUT = 255,
  localparam int RW          = $clog2(N_REGS),
  localparam int CW          = $clog2(LOAD_TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_we,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_result,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  input  logic            dbus_err,
  output logic            wb_we,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            retired,
  output logic            load_fault,
  output logic            busy
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          l_we;
  logic [RW-1:0] l_rd;
  logic [2:0]    l_f3;
  logic [1:0]    l_a;

  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  // Selects the addressed byte or halfword and sign- or zero-extends it.
  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [XLEN-1:0] w);
    logic [XLEN-1:0] sb;
    logic [XLEN-1:0] sh;
    logic [7:0]      b;
    logic [15:0]     h;
    sb = w >> {a, 3'b000};
    sh = w >> {a[1], 4'b0000};
    b  = sb[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  extract = {{(XLEN-8){b[7]}}, b};
      3'b001:  extract = {{(XLEN-16){h[15]}}, h};
      3'b100:  extract = {{(XLEN-8){1'b0}}, b};
      3'b101:  extract = {{(XLEN-16){1'b0}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3);
    f3_legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state == WAIT_LOAD);

  // Handshake, load wait and timeout, plus the registered writeback outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      retired    <= 1'b0;
      load_fault <= 1'b0;
      l_we       <= 1'b0;
      l_rd       <= '0;
      l_f3       <= '0;
      l_a        <= '0;
    end else begin
      wb_we      <= 1'b0;
      retired    <= 1'b0;
      load_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_is_load) begin
              l_we  <= in_we;
              l_rd  <= in_rd;
              l_f3  <= in_funct3;
              l_a   <= in_addr_lo;
              cnt   <= '0;
              state <= WAIT_LOAD;
            end else begin
              retired <= 1'b1;
              // wb_rd/wb_data only move when a write actually happens
              if (in_we && (in_rd != '0)) begin
                wb_we   <= 1'b1;
                wb_rd   <= in_rd;
                wb_data <= in_result;
              end
            end
          end
        end
        WAIT_LOAD: begin
          if (dbus_rvalid) begin
            state   <= IDLE;
            retired <= 1'b1;
            if (dbus_err || !f3_legal(l_f3)) begin
              load_fault <= 1'b1;
            end else if (l_we && (l_rd != '0)) begin
              wb_we   <= 1'b1;
              wb_rd   <= l_rd;
              wb_data <= extract(l_f3, l_a, dbus_rdata);
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state      <= IDLE;
              retired    <= 1'b1;
              load_fault <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvee_wb_stage.sv
// Testbench for rvee_wb_stage: a directed vector table followed by random
// traffic checked against a behavioural model.
module tb_rvee_wb_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_we, in_is_load;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;
  logic        dbus_rvalid, dbus_err;
  logic [31:0] dbus_rdata;
  logic        wb_we, retired, load_fault, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rvee_wb_stage #(.XLEN(32), .N_REGS(32), .LOAD_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_rd(in_rd), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_result(in_result),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .retired(retired),
    .load_fault(load_fault), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, v, we, ld, rv, err;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [1:0] a;
    logic [31:0] res, rdat;
    logic rdy, owe, oret, oflt;
    logic [4:0] ord;
    logic [31:0] odat;
  } vec_t;

  function automatic vec_t mk(input int r, input int v, input int we, input int rd,
                              input int ld, input int f3, input int a, input int res,
                              input int rv, input int rdat, input int err,
                              input int rdy, input int owe, input int ord,
                              input int odat, input int oret, input int oflt);
    vec_t x;
    x.rst = 1'(r);  x.v = 1'(v);    x.we = 1'(we);  x.rd = 5'(rd);
    x.ld = 1'(ld);  x.f3 = 3'(f3);  x.a = 2'(a);    x.res = 32'(res);
    x.rv = 1'(rv);  x.rdat = 32'(rdat); x.err = 1'(err);
    x.rdy = 1'(rdy); x.owe = 1'(owe); x.ord = 5'(ord); x.odat = 32'(odat);
    x.oret = 1'(oret); x.oflt = 1'(oflt);
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rst = x.rst; in_valid = x.v; in_we = x.we; in_rd = x.rd; in_is_load = x.ld;
    in_funct3 = x.f3; in_addr_lo = x.a; in_result = x.res;
    dbus_rvalid = x.rv; dbus_rdata = x.rdat; dbus_err = x.err;
  endtask

  // Behavioural reference: one outstanding load and how long it has waited.
  bit          m_pend;
  int          m_age;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_a;

  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    longint unsigned u, val;
    u = longint'(w);
    case (f3)
      3'b000, 3'b100: val = (u / (64'd1 << (8 * a))) % 256;
      3'b001, 3'b101: val = (u / (64'd1 << (16 * a[1]))) % 65536;
      default:        val = u;
    endcase
    if (f3 == 3'b000 && val >= 128)   val = val + 64'hFFFF_FF00;
    if (f3 == 3'b001 && val >= 32768) val = val + 64'hFFFF_0000;
    return 32'(val);
  endfunction

  vec_t tbl[$];
  localparam int W = 32'h80AA_BBCC;

  initial begin
    vec_t x;
    // Reset with random inputs on the pins
    x = mk(0, 1, 1, 9, 1, 2, 1, 32'h5555_AAAA, 1, 32'h1357_9BDF, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      x.v = 1'($urandom); x.ld = 1'($urandom); x.rv = 1'($urandom);
      x.rd = 5'($urandom); x.res = $urandom;
      drive(x);
      @(posedge clk); #1;
    end
    chk("rst_we", wb_we, 0);       chk("rst_rd", wb_rd, 0);
    chk("rst_data", wb_data, 0);   chk("rst_ret", retired, 0);
    chk("rst_flt", load_fault, 0); chk("rst_rdy", in_ready, 1);
    chk("rst_busy", busy, 0);

    //               rst v we rd ld f3 a  res          rv rdat          err rdy owe ord odat           ret flt
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 32'h1234,    0, 0,            0,  1,  1,  5,  32'h1234,      1,  0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'hFFFF,    0, 0,            0,  1,  0,  0,  0,             1,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 1, 1, 7, 1, 0, 3, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  1,  7,  32'hFFFFFF80,  1,  0));
    tbl.push_back(mk(1, 1, 1, 9, 1, 5, 2, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  1,  9,  32'h000080AA,  1,  0));
    tbl.push_back(mk(1, 1, 1, 3, 1, 2, 1, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, 32'h12345678, 0,  0,  1,  3,  32'h12345678,  1,  0));
    tbl.push_back(mk(1, 1, 1, 4, 1, 1, 3, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  1,  4,  32'hFFFF80AA,  1,  0));
    tbl.push_back(mk(1, 1, 1, 6, 1, 4, 1, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  1,  6,  32'h000000BB,  1,  0));
    // bus error, then illegal funct3
    tbl.push_back(mk(1, 1, 1, 8, 1, 2, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            1,  0,  0,  0,  0,             1,  1));
    tbl.push_back(mk(1, 1, 1, 8, 1, 3, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  0,  0,  0,             1,  1));
    // rd=0 load and we=0 load retire without writing
    tbl.push_back(mk(1, 1, 1, 0, 1, 2, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  0,  0,  0,             1,  0));
    tbl.push_back(mk(1, 1, 0, 2, 1, 0, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  0,  0,  0,  0,             1,  0));
    // timeout: accept at N, busy N+1..N+4, fault after N+4
    tbl.push_back(mk(1, 1, 1, 10, 1, 2, 0, 0,          0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  0,  0,  0,  0,             1,  1));
    // stray response in IDLE is dropped
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  1,  0,  0,  0,             0,  0));
    // response on the last honoured cycle wins; in_valid while busy ignored
    tbl.push_back(mk(1, 1, 1, 11, 1, 2, 0, 0,          0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 1, 1, 12, 0, 0, 0, 32'hDEAD,   0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 1, 1, 12, 0, 0, 0, 32'hDEAD,   0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 1, 1, 12, 0, 0, 0, 32'hDEAD,   0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, 32'hCAFEF00D, 0,  0,  1,  11, 32'hCAFEF00D,  1,  0));
    // reset mid-load, late response dropped
    tbl.push_back(mk(1, 1, 1, 13, 1, 2, 0, 0,          0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  0,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           1, W,            0,  1,  0,  0,  0,             0,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,           0, 0,            0,  1,  0,  0,  0,             0,  0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].rdy);
      chk($sformatf("v%0d_busy", i), busy, !tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), wb_we, tbl[i].owe);
      chk($sformatf("v%0d_ret", i), retired, tbl[i].oret);
      chk($sformatf("v%0d_flt", i), load_fault, tbl[i].oflt);
      if (tbl[i].owe) begin
        chk($sformatf("v%0d_rd", i), wb_rd, tbl[i].ord);
        chk($sformatf("v%0d_data", i), wb_data, tbl[i].odat);
      end
    end

    // Random traffic against the reference model (table ends in IDLE)
    m_pend = 0; m_age = 0; m_we = 0; m_rd = '0; m_f3 = '0; m_a = '0;
    for (int c = 0; c < 3000; c++) begin
      logic e_we, e_ret, e_flt, e_dchk;
      logic [4:0] e_rd;
      logic [31:0] e_dat;
      rst         = ($urandom_range(49) != 0);
      in_valid    = 1'($urandom);
      in_is_load  = 1'($urandom);
      in_we       = ($urandom_range(7) != 0);
      in_rd       = 5'($urandom);
      in_funct3   = 3'($urandom);
      in_addr_lo  = 2'($urandom);
      in_result   = $urandom;
      dbus_rvalid = ($urandom_range(2) == 0);
      dbus_rdata  = $urandom;
      dbus_err    = ($urandom_range(7) == 0);
      chk("r_rdy", in_ready, !m_pend);
      chk("r_busy", busy, m_pend);

      e_we = 0; e_ret = 0; e_flt = 0; e_dchk = 0; e_rd = '0; e_dat = '0;
      if (!rst) begin
        m_pend = 0;
        e_dchk = 1;
      end else if (!m_pend) begin
        if (in_valid && in_is_load) begin
          m_pend = 1; m_age = 0;
          m_we = in_we; m_rd = in_rd; m_f3 = in_funct3; m_a = in_addr_lo;
        end else if (in_valid) begin
          e_ret = 1;
          e_we  = in_we && (in_rd != 0);
          e_dchk = e_we; e_rd = in_rd; e_dat = in_result;
        end
      end else if (dbus_rvalid) begin
        m_pend = 0;
        e_ret  = 1;
        if (dbus_err || in_funct3 === 3'bx || !(m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
          e_flt = 1;
        else begin
          e_we = m_we && (m_rd != 0);
          e_dchk = e_we; e_rd = m_rd; e_dat = ref_extract(m_f3, m_a, dbus_rdata);
        end
      end else begin
        m_age++;
        if (m_age == T) begin
          m_pend = 0; e_ret = 1; e_flt = 1;
        end
      end

      @(posedge clk); #1;
      chk("r_we", wb_we, e_we);
      chk("r_ret", retired, e_ret);
      chk("r_flt", load_fault, e_flt);
      if (e_dchk) begin
        chk("r_rd", wb_rd, e_rd);
        chk("r_data", wb_data, e_dat);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvee_wb_stage.md
# rvee_wb_stage

Writeback stage of the RVee pipeline. It sits directly upstream of the register file write port. It accepts retiring instructions from the memory stage with a valid/ready handshake and, for loads, waits for the data-bus response. It then extracts and sign- or zero-extends the loaded byte, halfword or word and drives the one-cycle `wb_we`/`wb_rd`/`wb_data` write strobe that the register file consumes and forwards.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `N_REGS`, 32, number of architectural registers; the register index width is `$clog2(N_REGS)`.
- `LOAD_TIMEOUT`, 255, maximum number of cycles to wait for a load response; must be ≥1.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  memory stage presents an instruction.
- `in_ready`  out  1  stage can accept; combinational from state only.
- `in_we`  in  1  instruction writes `rd`.
- `in_rd`  in  `$clog2(N_REGS)`  destination register.
- `in_is_load`  in  1  instruction is a load.
- `in_funct3`  in  3  load width/sign encoding.
- `in_addr_lo`  in  2  load byte address bits [1:0].
- `in_result`  in  `XLEN`  ALU/CSR result for non-loads.
- `dbus_rvalid`  in  1  load response valid.
- `dbus_rdata`  in  `XLEN`  load response word, naturally aligned.
- `dbus_err`  in  1  bus error, qualified by `dbus_rvalid`.
- `wb_we`  out  1  register write strobe, registered.
- `wb_rd`  out  `$clog2(N_REGS)`  write index, registered.
- `wb_data`  out  `XLEN`  write data, registered.
- `retired`  out  1  one-cycle pulse per completed instruction, registered.
- `load_fault`  out  1  one-cycle pulse on bus error, illegal funct3 or timeout, registered.
- `busy`  out  1  high in `WAIT_LOAD`.

## Operation
- States are `IDLE` and `WAIT_LOAD`. `in_ready`=1 in `IDLE` and 0 in `WAIT_LOAD`; `busy` = (state==`WAIT_LOAD`).
- An instruction is accepted when `in_valid & in_ready`.
- **Non-load accept in `IDLE`:**
  - The next cycle has `wb_we`=`in_we & (in_rd!=0)`, `wb_rd`=`in_rd`, `wb_data`=`in_result`, `retired`=1.
  - The stage stays in `IDLE`, so back-to-back instructions run at one per cycle.
- **Load accept in `IDLE`:**
  - Latch `in_rd`, `in_we`, `in_funct3` and `in_addr_lo`.
  - Clear the timeout counter and go to `WAIT_LOAD`.
  - Outputs the next cycle: `wb_we`=0, `retired`=0.
- **`WAIT_LOAD` with `dbus_rvalid`=1:**
  - If `dbus_err`=1, or funct3 is not in {000,001,010,100,101}, the next cycle has `load_fault`=1, `retired`=1 and `wb_we`=0.
  - Otherwise the next cycle has `wb_data`=extract(`dbus_rdata`), `wb_we`=latched `we & (rd!=0)` and `retired`=1.
  - Either way the next state is `IDLE`.
- **`WAIT_LOAD` with `dbus_rvalid`=0:**
  - The counter increments.
  - If the counter was `LOAD_TIMEOUT-1`, the next cycle has `load_fault`=1, `retired`=1, `wb_we`=0, and the state goes to `IDLE`.
- **Load extraction:**
  - LB/LBU take byte `addr_lo` (bits `8*addr_lo+7 : 8*addr_lo`).
  - LH/LHU take halfword `addr_lo[1]`; `addr_lo[0]` is ignored (alignment is trapped upstream).
  - LW takes the full word, and `addr_lo` is ignored.
  - 000/001 sign-extend to `XLEN`; 100/101 zero-extend.
- **Other rules:**
  - `dbus_rvalid` in `IDLE` is ignored.
  - `rd`=0 never produces `wb_we`=1, but still pulses `retired`.
  - `wb_rd` and `wb_data` hold their last values when `wb_we`=0; the register file qualifies them with `wb_we`.
- **Reset:**
  - State `IDLE`, counter 0, `wb_we`=0, `wb_rd`=0, `wb_data`=0, `retired`=0, `load_fault`=0.
  - Reset in `WAIT_LOAD` abandons the load. A response arriving after reset lands in `IDLE` and is dropped.

## Timing
- Non-load: accepted in cycle N, written to the register file in cycle N+1 (`wb_we` high for exactly one cycle).
- Load: response in cycle M, `wb_we` high in cycle M+1; earliest next accept is cycle M+1.
- Timeout: for a load accepted in cycle N, the last honoured `dbus_rvalid` is at cycle N+`LOAD_TIMEOUT`. `load_fault` pulses in cycle N+`LOAD_TIMEOUT`+1 if no response has arrived.
- A response in the same cycle the counter expires wins; no fault is raised.
- `in_valid` held while `in_ready`=0 is not accepted; upstream must hold the instruction stable.

## Test plan
- **Reset:** `rst`=0 for 2 cycles with random inputs → all outputs 0, `in_ready`=1.
- **Back-to-back non-loads:** accept (rd=5, 0x1234) then (rd=0, 0xFFFF) on consecutive cycles → cycle+1: `wb_we`=1, `wb_rd`=5, `wb_data`=0x1234; cycle+2: `wb_we`=0, `retired`=1.
- **LB then LHU:** LB (addr_lo=3, rd=7) with `dbus_rdata`=0x80AA_BBCC → `wb_data`=0xFFFF_FF80. LHU (addr_lo=2) with the same word → `wb_data`=0x0000_80AA. Each write occurs one cycle after `dbus_rvalid`.
- **Bus error:** load with `dbus_rvalid`=1, `dbus_err`=1 → `load_fault`=1, `wb_we`=0 the next cycle. Funct3=011 with a valid response → `load_fault`=1.
- **Timeout:** `LOAD_TIMEOUT`=4, load accepted at cycle 10 with no response → `busy` high for cycles 11-14, `load_fault` at cycle 15. Repeat with `dbus_rvalid` at cycle 14 → normal write at cycle 15, no fault.
- **Reset mid-load:** assert `rst` at cycle 12 of a pending load, then `dbus_rvalid` at cycle 14 → no `wb_we`, no `retired`, `in_ready`=1.
